prog_fetch_arbiter: RTL
=======================

Name: prog_fetch_arbiter

Overview:
- Sequences the 256x16 combinational program ROM (8-bit address, 16-bit data) for the core.
- Generates fetch addresses and owns the program counter.
- Holds one fetched instruction in a single-entry instruction register with a valid/ready handshake to the decoder.
- Redirects on jumps, supports halt/resume, and time-shares the ROM read port with a debug readback requester, with bounded debug wait.

Parameters:
AW, 8, ROM address width
DW, 16, ROM data / instruction width
RESET_VEC, 8'h00, first fetch address after reset
DBG_MAX_WAIT, 4, cycles a pending debug request may be refused before a forced grant (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
rom_addr  out  AW  address to program ROM (combinational mux)
rom_data  in  DW  ROM read data, same-cycle combinational
ir  out  DW  instruction register
ir_valid  out  1  ir holds an unconsumed instruction
ir_ready  in  1  decoder accepts ir this cycle
pc  out  AW  address of the instruction in ir
jump_en  in  1  one-cycle redirect request
jump_addr  in  AW  redirect target
halt  in  1  stop fetching (pulse)
run  in  1  start/resume fetching (pulse)
running  out  1  high in FETCH state
dbg_req  in  1  debug read request, held until dbg_ack
dbg_addr  in  AW  debug read address, stable while dbg_req
dbg_data  out  DW  registered debug read data
dbg_ack  out  1  one-cycle pulse, dbg_data valid

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE; fetch_pc=RESET_VEC.
  - ir=0, ir_valid=0, pc=0, dbg_data=0, dbg_ack=0, running=0, debug wait counter=0.
  - Reset mid-operation discards the IR and any pending debug grant.
- States:
  - IDLE: no fetch; run moves to FETCH.
  - FETCH: running=1.
  - HALT: no fetch; run moves to FETCH. jump_en is ignored in IDLE and HALT.
- Fetch slot: exists in FETCH when (!ir_valid || ir_ready) and no debug grant this cycle.
  - rom_addr=fetch_pc; ir<=rom_data; pc<=fetch_pc; ir_valid<=1; fetch_pc<=fetch_pc+1.
  - fetch_pc wraps mod 2^AW (FF->00).
  - Zero-bubble throughput: one instruction per cycle while ir_ready is held high.
- Consume without refill (ir_ready && ir_valid, no fetch slot): ir_valid<=0.
- Jump (FETCH, jump_en=1, halt=0): highest priority, overrides stall and debug.
  - rom_addr=jump_addr; ir<=rom_data; pc<=jump_addr; ir_valid<=1; fetch_pc<=jump_addr+1.
  - The old ir is discarded whatever ir_ready is.
- Halt (FETCH, halt=1): next state HALT; ir_valid<=0.
  - If ir_valid && !ir_ready, fetch_pc<=pc so the unconsumed instruction is refetched on resume.
  - If consumed that cycle, fetch_pc is unchanged.
  - halt together with jump_en: fetch_pc<=jump_addr, no IR load, enter HALT.
- Debug arbitration:
  - Grant when dbg_req=1, dbg_ack=0, no jump_en in FETCH, and either:
    - the fetch path does not need the ROM (IDLE, HALT, or FETCH with ir_valid && !ir_ready), or
    - wait counter == DBG_MAX_WAIT (forced grant; the fetch slot is skipped that cycle and the IR/ir_valid are held).
  - On grant: rom_addr=dbg_addr; dbg_data<=rom_data; dbg_ack<=1 next cycle; counter<=0.
  - Counter increments (saturating at DBG_MAX_WAIT) each cycle dbg_req=1 without a grant, and clears when dbg_req=0.
  - No grant in a dbg_ack cycle, so one request gets exactly one ack.
- rom_addr mux priority: jump_addr > dbg_addr (granted) > fetch_pc.
- Simultaneous run and halt in IDLE/HALT: run wins.

Test Plan:
- Bench ROM model rom[a]={8'hA5,a}.
- Reset, then pulse run, ir_ready=1 constant -> ir_valid rises one cycle after run; successive ir = A500, A501, A502 with pc=00,01,02; no bubbles.
- ir_ready=0 for 3 cycles with ir=A503 -> ir and pc held stable, ir_valid=1; on ready, next ir=A504.
- jump_en=1, jump_addr=8'hF0 while ir_valid=1 and ir_ready=0 -> next cycle ir=A5F0, pc=F0. Continue fetching -> pc sequence F0..FF,00 (wrap).
- While stalled, dbg_req with dbg_addr=8'h3C -> dbg_ack one cycle after grant, dbg_data=A53C.
- With ir_ready=1 continuous, a dbg_req is held -> forced grant after exactly 4 refused cycles, a one-cycle fetch bubble, then a single dbg_ack.
- halt while ir=A507 is unconsumed -> state HALT, ir_valid=0, running=0. Pulse run -> ir=A507 refetched with pc=07.
- Assert rst_n=0 mid-stream -> ir_valid=0, running=0. After run -> first ir=A500.

Source files
------------

// File: rtl/prog_fetch_arbiter.sv
// prog_fetch_arbiter: program ROM sequencer with a single-entry instruction register
// and a debug readback port that shares the ROM, with a bounded wait before a forced grant.
module prog_fetch_arbiter #(
   parameter int AW = 8,
   parameter int DW = 16,
   parameter logic [AW-1:0] RESET_VEC = '0,
   parameter int DBG_MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic [DW-1:0] ir,
   output logic          ir_valid,
   input  logic          ir_ready,
   output logic [AW-1:0] pc,
   input  logic          jump_en,
   input  logic [AW-1:0] jump_addr,
   input  logic          halt,
   input  logic          run,
   output logic          running,
   input  logic          dbg_req,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data,
   output logic          dbg_ack
);
   localparam int CW = $clog2(DBG_MAX_WAIT + 1);
   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
   state_t state, state_n;
   logic [AW-1:0] fetch_pc;
   logic [CW-1:0] cnt;
   logic fetching, jump, needs_rom, grant, slot;
   assign fetching  = state == FETCH;
   assign running   = fetching;
   assign jump      = fetching && jump_en;
   assign needs_rom = fetching && (!ir_valid || ir_ready);
   // dbg_ack gating guarantees a single ack per held request
   assign grant     = dbg_req && !dbg_ack && !jump && (!needs_rom || cnt == CW'(DBG_MAX_WAIT));
   assign slot      = needs_rom && !grant;
   assign rom_addr  = jump ? jump_addr : grant ? dbg_addr : fetch_pc;
   always_comb begin
      state_n = state;
      if (fetching) begin
         if (halt) state_n = HALT;
      end else if (run) state_n = FETCH;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= RESET_VEC;
         ir       <= '0;
         ir_valid <= 1'b0;
         pc       <= '0;
         dbg_data <= '0;
         dbg_ack  <= 1'b0;
         cnt      <= '0;
      end else begin
         state   <= state_n;
         dbg_ack <= grant;
         if (grant) dbg_data <= rom_data;
         cnt <= grant || !dbg_req ? '0 : cnt == CW'(DBG_MAX_WAIT) ? cnt : cnt + 1'b1;
         if (fetching && halt) begin
            ir_valid <= 1'b0;
            // an unconsumed instruction is refetched on resume
            if (jump_en) fetch_pc <= jump_addr;
            else if (ir_valid && !ir_ready) fetch_pc <= pc;
         end else if (jump) begin
            ir       <= rom_data;
            pc       <= jump_addr;
            ir_valid <= 1'b1;
            fetch_pc <= jump_addr + 1'b1;
         end else if (slot) begin
            ir       <= rom_data;
            pc       <= fetch_pc;
            ir_valid <= 1'b1;
            fetch_pc <= fetch_pc + 1'b1;
         end else if (ir_valid && ir_ready) ir_valid <= 1'b0;
      end
   end
endmodule
